cb_arb: RTL and testbench

//  Controller for one 2-wide circular buffer (cb): shares its two enqueue slots between two

---
 rtl/cb_pkg.sv | 24 ++
 rtl/cb_rr_pick.sv | 70 +++++++
 rtl/cb_arb.sv | 172 +++++++++++++++++
 tb/tb_cb_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared definitions for the cb_arb circular-buffer controller: FSM encoding,
// default depth and small count helpers. Optional build macro used by cb_arb: CB_ARB_STATS_EN.
package cb_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int unsigned CB_IDX_DFLT = 3;
  localparam int unsigned DEPTH       = 1 << CB_IDX_DFLT;

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

  // A count field of 3 means "as many as a 2-wide buffer can take".
  function automatic logic [1:0] sat2(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  function automatic logic [1:0] clip2(input logic [31:0] v);
    return (v > 32'd2) ? 2'd2 : v[1:0];
  endfunction

endpackage

// File: rtl/cb_rr_pick.sv
// Two-requester all-or-nothing round-robin grant and packing of granted
// entries onto the two cb write lanes (priority requester first, din1 first).
module cb_rr_pick #(
  parameter int CB_WIDTH = 8
) (
  input  logic                prio,
  input  logic [1:0]          cnt0,
  input  logic [1:0]          cnt1,
  input  logic [1:0]          slots,
  input  logic [CB_WIDTH-1:0] d0_1,
  input  logic [CB_WIDTH-1:0] d0_2,
  input  logic [CB_WIDTH-1:0] d1_1,
  input  logic [CB_WIDTH-1:0] d1_2,
  output logic                gnt0,
  output logic                gnt1,
  output logic                prio_gnt,
  output logic [1:0]          push_cnt,
  output logic [CB_WIDTH-1:0] din1,
  output logic [CB_WIDTH-1:0] din2,
  output logic                din1_en,
  output logic                din2_en
);

  logic [1:0]          cp, co, np, no, rem;
  logic                gp, go;
  logic [CB_WIDTH-1:0] pd1, pd2, od1, od2;

  // grant decision and lane packing
  always_comb begin
    cp  = prio ? cnt1 : cnt0;
    co  = prio ? cnt0 : cnt1;
    pd1 = prio ? d1_1 : d0_1;
    pd2 = prio ? d1_2 : d0_2;
    od1 = prio ? d0_1 : d1_1;
    od2 = prio ? d0_2 : d1_2;

    gp  = (cp != 2'd0) && (cp <= slots);
    np  = gp ? cp : 2'd0;
    rem = slots - np;
    go  = (co != 2'd0) && (co <= rem);
    no  = go ? co : 2'd0;

    push_cnt = np + no;
    prio_gnt = gp;
    gnt0     = prio ? go : gp;
    gnt1     = prio ? gp : go;

    if (np != 2'd0) begin
      din1 = pd1;
    end else if (no != 2'd0) begin
      din1 = od1;
    end else begin
      din1 = {CB_WIDTH{1'b0}};
    end

    if (np == 2'd2) begin
      din2 = pd2;
    end else if ((np == 2'd1) && (no != 2'd0)) begin
      din2 = od1;
    end else if (no == 2'd2) begin
      din2 = od2;
    end else begin
      din2 = {CB_WIDTH{1'b0}};
    end

    din1_en = (push_cnt != 2'd0);
    din2_en = (push_cnt == 2'd2);
  end

endmodule

// File: rtl/cb_arb.sv
// Controller for one 2-wide circular buffer: push arbitration, pops, tail squash,
// flush sequencing and shadow-occupancy cross-check. Optional macro: CB_ARB_STATS_EN.
module cb_arb
  import cb_pkg::*;
#(
  parameter int CB_IDX   = 3,
  parameter int CB_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req0_cnt,
  input  logic [CB_WIDTH-1:0] req0_d1,
  input  logic [CB_WIDTH-1:0] req0_d2,
  input  logic [1:0]          req1_cnt,
  input  logic [CB_WIDTH-1:0] req1_d1,
  input  logic [CB_WIDTH-1:0] req1_d2,
  output logic                gnt0,
  output logic                gnt1,
  input  logic [1:0]          pop_req,
  output logic [1:0]          pop_gnt,
  input  logic                squash,
  input  logic [CB_IDX-1:0]   squash_cnt,
  input  logic                flush_req,
  output logic                flush_done,
  output logic [CB_WIDTH-1:0] din1,
  output logic [CB_WIDTH-1:0] din2,
  output logic                din1_en,
  output logic                din2_en,
  output logic                dout1_req,
  output logic                dout2_req,
  output logic                move_tail,
  output logic [CB_IDX-1:0]   tail_offset,
  input  logic                cb_full,
  input  logic                cb_full_almost,
  output logic [CB_IDX:0]     occ,
  output logic                sync_err,
  output logic [15:0]         stall_cnt0,
  output logic [15:0]         stall_cnt1
);

  localparam int OW = CB_IDX + 1;
  localparam logic [CB_IDX:0] DEPTH_L = OW'(1 << CB_IDX);

  logic [0:0]        state_q, state_d;
  logic [CB_IDX:0]   occ_q, occ_d, occ_nx, free_s;
  logic              rr_q, rr_d;
  logic              sync_err_q, sync_err_d;
  logic              run_s, flushing_s, sq_act_s, prio_gnt_s;
  logic [1:0]        slots_s, push_s, pop_s;
  logic [CB_IDX-1:0] tail_off_s, retract_s;

  // squash qualification and push capacity for this cycle
  always_comb begin
    run_s      = !reset;
    flushing_s = (state_q == ST_FLUSH);
    sq_act_s   = run_s && !flushing_s && squash && (squash_cnt != {CB_IDX{1'b0}});
    free_s     = DEPTH_L - occ_q;
    if (!run_s || flushing_s || sq_act_s) begin
      slots_s = 2'd0;
    end else begin
      slots_s = clip2(32'(free_s));
    end
  end

  cb_rr_pick #(.CB_WIDTH(CB_WIDTH)) u_pick (
    .prio     (rr_q),
    .cnt0     (sat2(req0_cnt)),
    .cnt1     (sat2(req1_cnt)),
    .slots    (slots_s),
    .d0_1     (req0_d1),
    .d0_2     (req0_d2),
    .d1_1     (req1_d1),
    .d1_2     (req1_d2),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .prio_gnt (prio_gnt_s),
    .push_cnt (push_s),
    .din1     (din1),
    .din2     (din2),
    .din1_en  (din1_en),
    .din2_en  (din2_en)
  );

  // pops, retraction, occupancy update and FSM next state
  always_comb begin
    tail_off_s = ({1'b0, squash_cnt} < occ_q) ? squash_cnt : occ_q[CB_IDX-1:0];
    retract_s  = sq_act_s ? tail_off_s : {CB_IDX{1'b0}};

    if (!run_s) begin
      pop_s = 2'd0;
    end else if (flushing_s) begin
      pop_s = clip2(32'(occ_q));
    end else if (sq_act_s) begin
      pop_s = 2'd0;
    end else begin
      pop_s = min2(sat2(pop_req), clip2(32'(occ_q)));
    end

    occ_nx     = occ_q + OW'(push_s) - OW'(pop_s) - OW'(retract_s);
    flush_done = run_s && flushing_s && (occ_nx == {OW{1'b0}});
    occ_d      = occ_nx;
    rr_d       = prio_gnt_s ? ~rr_q : rr_q;
    sync_err_d = sync_err_q
               | (cb_full != (occ_q == DEPTH_L))
               | (cb_full_almost != (occ_q == (DEPTH_L - OW'(1))));

    case (state_q)
      ST_RUN:   state_d = flush_req ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = (occ_nx == {OW{1'b0}}) ? ST_RUN : ST_FLUSH;
      default:  state_d = ST_RUN;
    endcase
  end

  // controller state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      occ_q      <= {OW{1'b0}};
      rr_q       <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      rr_q       <= rr_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign pop_gnt     = pop_s;
  assign dout1_req   = (pop_s != 2'd0);
  assign dout2_req   = (pop_s == 2'd2);
  assign move_tail   = sq_act_s;
  assign tail_offset = retract_s;
  assign occ         = occ_q;
  assign sync_err    = sync_err_q;

`ifdef CB_ARB_STATS_EN
  logic [15:0] stall0_q, stall0_d, stall1_q, stall1_d;

  // saturating stall counters: request present but not granted
  always_comb begin
    if ((req0_cnt != 2'd0) && !gnt0 && (stall0_q != 16'hFFFF)) begin
      stall0_d = stall0_q + 16'd1;
    end else begin
      stall0_d = stall0_q;
    end
    if ((req1_cnt != 2'd0) && !gnt1 && (stall1_q != 16'hFFFF)) begin
      stall1_d = stall1_q + 16'd1;
    end else begin
      stall1_d = stall1_q;
    end
  end

  // stall counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall0_q <= 16'h0000;
      stall1_q <= 16'h0000;
    end else begin
      stall0_q <= stall0_d;
      stall1_q <= stall1_d;
    end
  end

  assign stall_cnt0 = stall0_q;
  assign stall_cnt1 = stall1_q;
`else
  assign stall_cnt0 = 16'h0000;
  assign stall_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_cb_arb.sv
// Scoreboard bench for cb_arb (CB_IDX=3): directed scenarios then random traffic,
// each cycle checked against a slot/queue-level reference model of the controller.
module tb_cb_arb;

`ifdef CB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req0_cnt, req1_cnt, pop_req, pop_gnt;
  logic [7:0] req0_d1, req0_d2, req1_d1, req1_d2, din1, din2;
  logic       gnt0, gnt1, squash, flush_req, flush_done;
  logic [2:0] squash_cnt, tail_offset;
  logic       din1_en, din2_en, dout1_req, dout2_req, move_tail;
  logic       cb_full, cb_full_almost, sync_err;
  logic [3:0] occ;
  logic [15:0] stall_cnt0, stall_cnt1;

  cb_arb #(.CB_IDX(3), .CB_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_cnt(req0_cnt), .req0_d1(req0_d1), .req0_d2(req0_d2),
    .req1_cnt(req1_cnt), .req1_d1(req1_d1), .req1_d2(req1_d2),
    .gnt0(gnt0), .gnt1(gnt1), .pop_req(pop_req), .pop_gnt(pop_gnt),
    .squash(squash), .squash_cnt(squash_cnt), .flush_req(flush_req), .flush_done(flush_done),
    .din1(din1), .din2(din2), .din1_en(din1_en), .din2_en(din2_en),
    .dout1_req(dout1_req), .dout2_req(dout2_req), .move_tail(move_tail), .tail_offset(tail_offset),
    .cb_full(cb_full), .cb_full_almost(cb_full_almost), .occ(occ), .sync_err(sync_err),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gnt0, gnt1, pop, din1, din2, en1, en2, mt, toff, fd, occ, serr, st0, st1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_occ = 0, m_rr = 0, m_st0 = 0, m_st1 = 0;
  bit m_flush = 1'b0, m_serr = 1'b0;
  bit force_full = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drive one cycle: compute the expected response, queue it, advance the clock.
  task automatic cycle();
    exp_t e;
    int cnt[2];
    int dat[2][2];
    bit g[2];
    int ent[$];
    int slots, rem, r, pops, ret, occn;
    bit sq;
    req0_d1 = 8'($urandom); req0_d2 = 8'($urandom);
    req1_d1 = 8'($urandom); req1_d2 = 8'($urandom);
    cb_full        = (m_occ == 8) ^ force_full;
    cb_full_almost = (m_occ == 7);
    e = '{default: 0};
    e.occ = m_occ; e.serr = m_serr; e.st0 = m_st0; e.st1 = m_st1;
    if (reset) begin
      m_occ = 0; m_rr = 0; m_flush = 1'b0; m_serr = 1'b0; m_st0 = 0; m_st1 = 0;
    end else begin
      cnt[0] = imin(int'(req0_cnt), 2);
      cnt[1] = imin(int'(req1_cnt), 2);
      dat[0][0] = int'(req0_d1); dat[0][1] = int'(req0_d2);
      dat[1][0] = int'(req1_d1); dat[1][1] = int'(req1_d2);
      sq    = !m_flush && squash && (squash_cnt != 3'd0);
      slots = (m_flush || sq) ? 0 : imin(2, 8 - m_occ);
      rem   = slots;
      g[0]  = 1'b0; g[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        r = (m_rr + k) % 2;
        if (cnt[r] > 0 && cnt[r] <= rem) begin
          g[r] = 1'b1;
          rem -= cnt[r];
          for (int j = 0; j < cnt[r]; j++) ent.push_back(dat[r][j]);
        end
      end
      e.gnt0 = g[0]; e.gnt1 = g[1];
      e.en1  = (ent.size() >= 1); e.en2 = (ent.size() == 2);
      e.din1 = (ent.size() >= 1) ? ent[0] : 0;
      e.din2 = (ent.size() == 2) ? ent[1] : 0;
      if (m_flush)  pops = imin(2, m_occ);
      else if (sq)  pops = 0;
      else          pops = imin(imin(int'(pop_req), 2), m_occ);
      ret    = sq ? imin(int'(squash_cnt), m_occ) : 0;
      e.pop  = pops; e.mt = sq; e.toff = ret;
      occn   = m_occ + ent.size() - pops - ret;
      e.fd   = m_flush && (occn == 0);
      if (STATS && cnt[0] > 0 && !g[0] && m_st0 < 65535) m_st0++;
      if (STATS && cnt[1] > 0 && !g[1] && m_st1 < 65535) m_st1++;
      if ((cb_full != (m_occ == 8)) || (cb_full_almost != (m_occ == 7))) m_serr = 1'b1;
      if (g[m_rr]) m_rr = 1 - m_rr;
      m_flush = m_flush ? (occn != 0) : flush_req;
      m_occ   = occn;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // monitor: compare DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("gnt0", int'(gnt0), e.gnt0);
      chk("gnt1", int'(gnt1), e.gnt1);
      chk("pop_gnt", int'(pop_gnt), e.pop);
      chk("dout1_req", int'(dout1_req), int'(e.pop >= 1));
      chk("dout2_req", int'(dout2_req), int'(e.pop == 2));
      chk("din1", int'(din1), e.din1);
      chk("din2", int'(din2), e.din2);
      chk("din1_en", int'(din1_en), e.en1);
      chk("din2_en", int'(din2_en), e.en2);
      chk("move_tail", int'(move_tail), e.mt);
      chk("tail_offset", int'(tail_offset), e.toff);
      chk("flush_done", int'(flush_done), e.fd);
      chk("occ", int'(occ), e.occ);
      chk("sync_err", int'(sync_err), e.serr);
      chk("stall_cnt0", int'(stall_cnt0), e.st0);
      chk("stall_cnt1", int'(stall_cnt1), e.st1);
    end
  end

  task automatic idle();
    req0_cnt = 2'd0; req1_cnt = 2'd0; pop_req = 2'd0;
    squash = 1'b0; squash_cnt = 3'd0; flush_req = 1'b0; force_full = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    req0_cnt = 2'd2;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
  endtask

  task automatic push_to_five();
    req0_cnt = 2'd2; cycle();
    cycle();
    req0_cnt = 2'd1; cycle();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    req0_d1 = 8'd0; req0_d2 = 8'd0; req1_d1 = 8'd0; req1_d2 = 8'd0;
    cb_full = 1'b0; cb_full_almost = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // fill to full with requester 0 only, including request 3 treated as 2
    req0_cnt = 2'd2; cycle(); cycle();
    req0_cnt = 2'd3; cycle(); cycle(); cycle();
    idle(); cycle();

    // both requesters share slots, then priority flips
    do_reset();
    req0_cnt = 2'd1; req1_cnt = 2'd1; cycle();
    req0_cnt = 2'd2; req1_cnt = 2'd1; cycle();
    idle();

    // one free slot: only the request that fits is granted
    do_reset();
    req0_cnt = 2'd2; cycle(); cycle();
    idle(); req1_cnt = 2'd2; cycle();
    req1_cnt = 2'd1; cycle();
    req0_cnt = 2'd2; req1_cnt = 2'd1; cycle();
    idle(); cycle();

    // squash blocks pushes/pops and clips retraction to occupancy
    do_reset();
    push_to_five();
    squash = 1'b1; squash_cnt = 3'd3; req0_cnt = 2'd2; pop_req = 2'd1; cycle();
    idle(); squash = 1'b1; squash_cnt = 3'd6; cycle();
    idle(); cycle();

    // flush from occ=5 with requests held during the drain
    do_reset();
    push_to_five();
    flush_req = 1'b1; cycle();
    flush_req = 1'b0; req0_cnt = 2'd2; pop_req = 2'd0;
    for (int i = 0; i < 3; i++) cycle();
    idle(); cycle();
    // flush of an empty buffer
    flush_req = 1'b1; cycle();
    idle(); cycle(); cycle();

    // cb flag disagreement is sticky until reset
    do_reset();
    req0_cnt = 2'd2; cycle();
    req0_cnt = 2'd1; cycle();
    idle(); force_full = 1'b1; cycle();
    idle(); cycle(); cycle(); cycle();
    do_reset();
    cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      req0_cnt   = 2'($urandom_range(0, 3));
      req1_cnt   = 2'($urandom_range(0, 3));
      pop_req    = 2'($urandom_range(0, 2));
      squash     = ($urandom_range(0, 9) == 0);
      squash_cnt = 3'($urandom_range(0, 7));
      flush_req  = ($urandom_range(0, 19) == 0);
      force_full = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    cycle();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
